// File: rtl/maze_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : maze_fsm
//  Purpose  : Tiny maze game controller. A player walks a COLS x ROWS grid
//             one room per accepted direction request, collects the sword,
//             and fights the dragon: win with the sword, die without it.
//             WIN and DEAD are terminal until reset.
//  Ports    : clk            - rising-edge clock
//             reset          - synchronous, active-low reset
//             n, s, e, w     - direction requests (exactly one = valid move)
//             pos_x, pos_y   - current room
//             sw             - sword held
//             bump           - one-cycle pulse after a move into a wall
//             win, d         - registered terminal-state flags
//             moves          - accepted move count, saturating at 255
//  Options  : MAZE_MOVE_LIMIT_EN - when defined, reaching MAX_MOVES accepted
//             moves in EXPLORE kills the player (entering the dragon room
//             on that same move still starts the fight).
//  Revision : 1.0 - initial release
// ============================================================================
module maze_fsm #(
   parameter int COLS      = 4,
   parameter int ROWS      = 4,
   parameter int START_X   = 0,
   parameter int START_Y   = 0,
   parameter int SWORD_X   = 3,
   parameter int SWORD_Y   = 0,
   parameter int DRAGON_X  = 3,
   parameter int DRAGON_Y  = 3,
   parameter int MAX_MOVES = 32
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      n,
   input  logic                      s,
   input  logic                      e,
   input  logic                      w,
   output logic [$clog2(COLS)-1:0]   pos_x,
   output logic [$clog2(ROWS)-1:0]   pos_y,
   output logic                      sw,
   output logic                      bump,
   output logic                      win,
   output logic                      d,
   output logic [7:0]                moves
);

   localparam int XW = $clog2(COLS);
   localparam int YW = $clog2(ROWS);

   localparam logic [XW-1:0] X_MAX    = XW'(COLS - 1);
   localparam logic [YW-1:0] Y_MAX    = YW'(ROWS - 1);
   localparam logic [XW-1:0] X_ONE    = XW'(1);
   localparam logic [YW-1:0] Y_ONE    = YW'(1);
   localparam logic [XW-1:0] START_XC = XW'(START_X);
   localparam logic [YW-1:0] START_YC = YW'(START_Y);
   localparam logic [XW-1:0] SWORD_XC = XW'(SWORD_X);
   localparam logic [YW-1:0] SWORD_YC = YW'(SWORD_Y);
   localparam logic [XW-1:0] DRAG_XC  = XW'(DRAGON_X);
   localparam logic [YW-1:0] DRAG_YC  = YW'(DRAGON_Y);
`ifdef MAZE_MOVE_LIMIT_EN
   localparam logic [7:0]    MOVE_LIMIT = 8'(MAX_MOVES);
`endif

   // Elaboration-time guard on the configuration space.
   if (COLS < 2 || COLS > 16 || ROWS < 2 || ROWS > 16 ||
       MAX_MOVES < 1 || MAX_MOVES > 255) begin : g_bad_params
      $error("maze_fsm: parameter out of range");
   end

   typedef enum logic [1:0] {
      ST_EXPLORE = 2'd0,
      ST_FIGHT   = 2'd1,
      ST_WIN     = 2'd2,
      ST_DEAD    = 2'd3
   } state_t;

   state_t          state_q, state_d;
   logic [XW-1:0]   pos_x_q, pos_x_d;
   logic [YW-1:0]   pos_y_q, pos_y_d;
   logic            sw_q, sw_d;
   logic            bump_q, bump_d;
   logic            win_q, win_d;
   logic            dead_q, dead_d;
   logic [7:0]      moves_q, moves_d;

   logic            req_valid;
   logic            hit_wall;
   logic [XW-1:0]   tgt_x;
   logic [YW-1:0]   tgt_y;
   logic [7:0]      moves_inc;

   // Target room for the (single) requested direction, and whether it
   // lies outside the grid.
   always_comb begin
      req_valid = $onehot({n, s, e, w});
      tgt_x     = pos_x_q;
      tgt_y     = pos_y_q;
      hit_wall  = 1'b0;
      if (n) begin
         if (pos_y_q == '0) hit_wall = 1'b1;
         else               tgt_y    = pos_y_q - Y_ONE;
      end else if (s) begin
         if (pos_y_q == Y_MAX) hit_wall = 1'b1;
         else                  tgt_y    = pos_y_q + Y_ONE;
      end else if (e) begin
         if (pos_x_q == X_MAX) hit_wall = 1'b1;
         else                  tgt_x    = pos_x_q + X_ONE;
      end else if (w) begin
         if (pos_x_q == '0) hit_wall = 1'b1;
         else               tgt_x    = pos_x_q - X_ONE;
      end
      moves_inc = (moves_q == 8'hFF) ? 8'hFF : moves_q + 8'd1;
   end

   always_comb begin
      state_d = state_q;
      pos_x_d = pos_x_q;
      pos_y_d = pos_y_q;
      sw_d    = sw_q;
      moves_d = moves_q;
      bump_d  = 1'b0;

      case (state_q)
         ST_EXPLORE: begin
            if (req_valid) begin
               if (hit_wall) begin
                  bump_d = 1'b1;
               end else begin
                  pos_x_d = tgt_x;
                  pos_y_d = tgt_y;
                  moves_d = moves_inc;
                  if (tgt_x == SWORD_XC && tgt_y == SWORD_YC)
                     sw_d = 1'b1;
                  // Dragon entry outranks the move limit.
                  if (tgt_x == DRAG_XC && tgt_y == DRAG_YC)
                     state_d = ST_FIGHT;
`ifdef MAZE_MOVE_LIMIT_EN
                  else if (moves_inc == MOVE_LIMIT)
                     state_d = ST_DEAD;
`endif
               end
            end
         end
         ST_FIGHT: state_d = sw_q ? ST_WIN : ST_DEAD;
         default:  ; // WIN / DEAD: everything frozen
      endcase

      win_d  = (state_d == ST_WIN);
      dead_d = (state_d == ST_DEAD);
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q <= ST_EXPLORE;
         pos_x_q <= START_XC;
         pos_y_q <= START_YC;
         sw_q    <= 1'b0;
         bump_q  <= 1'b0;
         win_q   <= 1'b0;
         dead_q  <= 1'b0;
         moves_q <= 8'd0;
      end else begin
         state_q <= state_d;
         pos_x_q <= pos_x_d;
         pos_y_q <= pos_y_d;
         sw_q    <= sw_d;
         bump_q  <= bump_d;
         win_q   <= win_d;
         dead_q  <= dead_d;
         moves_q <= moves_d;
      end
   end

   assign pos_x = pos_x_q;
   assign pos_y = pos_y_q;
   assign sw    = sw_q;
   assign bump  = bump_q;
   assign win   = win_q;
   assign d     = dead_q;
   assign moves = moves_q;

endmodule
`default_nettype wire
